b_load_controller: RTL and testbench

//  Sequences the loading of operand B into the display datapath from a raw, bouncy push-button.
//  - Synchronises and debounces the active-low load key and the B switches.
//  - Issues exactly one single-cycle load per physical press and holds the captured 2-bit B value.
//  - Sits between the board KEY/SW pins and the B operand input of Decoder1, replacing the
//    key-clocked 2-bit flip-flop with a clean single-clock-domain load path.

---
 rtl/b_ctrl_pkg.sv | 13 +
 rtl/sync2.sv | 27 ++
 rtl/b_load_controller.sv | 126 ++++++++++++
 tb/tb_b_load_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/b_ctrl_pkg.sv
// Shared types and constants for the operand-B load controller.
package b_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } b_ctrl_state_t;

  localparam int unsigned DEBOUNCE_20MS_50MHZ = 1_000_000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous board inputs, with a configurable reset value.
module sync2 #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/b_load_controller.sv
// Debounced single-shot load of the 2-bit B operand from a bouncy active-low push-button.
module b_load_controller
  import b_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load_n,
  input  logic [1:0]       sw_b,
  output logic [1:0]       b_q,
  output logic             b_load,
  output logic             b_valid,
  output logic             busy,
  output logic [CNT_W-1:0] load_count
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES + 1 > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DBNC_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic             w_key_s;
  logic [1:0]       w_sw_s;

  b_ctrl_state_t    r_state;
  b_ctrl_state_t    w_state_nxt;
  logic [DW-1:0]    r_dbnc_cnt;
  logic [DW-1:0]    w_dbnc_cnt_nxt;

  logic [1:0]       r_b_q;
  logic             r_b_load;
  logic             r_b_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_load_count;

  // Key idles high (released), switches idle low.
  sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_key (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (key_load_n),
    .o_q   (w_key_s)
  );

  sync2 #(.W(2), .RST_VAL(2'b00)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sw_b),
    .o_q   (w_sw_s)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_dbnc_cnt_nxt = r_dbnc_cnt;
    case (r_state)
      IDLE: begin
        if (!w_key_s) begin
          w_state_nxt    = DEBOUNCE;
          w_dbnc_cnt_nxt = '0;
        end
      end
      DEBOUNCE: begin
        if (w_key_s) begin
          w_state_nxt = IDLE;
        end else if (r_dbnc_cnt == DBNC_LAST) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_dbnc_cnt_nxt = r_dbnc_cnt + DW'(1);
        end
      end
      CAPTURE: begin
        w_state_nxt    = WAIT_RELEASE;
        w_dbnc_cnt_nxt = '0;
      end
      WAIT_RELEASE: begin
        // Any low sample (bounce or continued hold) restarts the release window.
        if (!w_key_s) begin
          w_dbnc_cnt_nxt = '0;
        end else if (r_dbnc_cnt == DBNC_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_dbnc_cnt_nxt = r_dbnc_cnt + DW'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_dbnc_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dbnc_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dbnc_cnt <= w_dbnc_cnt_nxt;
    end
  end

  // Flags are registered from the next state so they line up exactly with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_q        <= 2'b00;
      r_b_load     <= 1'b0;
      r_b_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_load_count <= '0;
    end else begin
      r_b_load <= (w_state_nxt == CAPTURE);
      r_busy   <= (w_state_nxt != IDLE);
      if (r_state == CAPTURE) begin
        r_b_q        <= w_sw_s;
        r_b_valid    <= 1'b1;
        r_load_count <= r_load_count + CNT_W'(1);
      end
    end
  end

  assign b_q        = r_b_q;
  assign b_load     = r_b_load;
  assign b_valid    = r_b_valid;
  assign busy       = r_busy;
  assign load_count = r_load_count;

endmodule

// File: tb/tb_b_load_controller.sv
// Directed self-checking bench for b_load_controller with a 4-cycle debounce window.
module tb_b_load_controller;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             key_load_n;
  logic [1:0]       sw_b;
  logic [1:0]       b_q;
  logic             b_load;
  logic             b_valid;
  logic             busy;
  logic [CNT_W-1:0] load_count;

  int tests;
  int fails;
  int pulses;

  b_load_controller #(.DEBOUNCE_CYCLES(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load_n (key_load_n),
    .sw_b       (sw_b),
    .b_q        (b_q),
    .b_load     (b_load),
    .b_valid    (b_valid),
    .busy       (busy),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (b_load === 1'b1) pulses++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_load_n = 1'b1; sw_b = 2'b00;
    step(3);
    rst_n = 1'b1;
    step(2);
    tests++; if (b_q !== 2'b00)   begin fails++; $display("FAIL reset_b_q: got %b expected 00", b_q); end
    tests++; if (b_load !== 1'b0) begin fails++; $display("FAIL reset_b_load: got %b expected 0", b_load); end
    tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid: got %b expected 0", b_valid); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (load_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", load_count); end
  endtask

  task automatic test_clean_press();
    int p0;
    p0 = pulses;
    sw_b = 2'b10; key_load_n = 1'b0;
    step(6);   // after edge 5
    tests++; if (b_load !== 1'b0) begin fails++; $display("FAIL clean_early_load: got %b expected 0", b_load); end
    tests++; if (busy !== 1'b1)   begin fails++; $display("FAIL clean_busy: got %b expected 1", busy); end
    step(1);   // after edge 6
    tests++; if (b_load !== 1'b1) begin fails++; $display("FAIL clean_load_edge6: got %b expected 1", b_load); end
    tests++; if (b_q !== 2'b00)   begin fails++; $display("FAIL clean_b_q_early: got %b expected 00", b_q); end
    step(1);   // after edge 7
    tests++; if (b_load !== 1'b0) begin fails++; $display("FAIL clean_load_width: got %b expected 0", b_load); end
    tests++; if (b_q !== 2'b10)   begin fails++; $display("FAIL clean_b_q: got %b expected 10", b_q); end
    tests++; if (b_valid !== 1'b1) begin fails++; $display("FAIL clean_valid: got %b expected 1", b_valid); end
    tests++; if (load_count !== 4'd1) begin fails++; $display("FAIL clean_count: got %0d expected 1", load_count); end
    step(12);  // key held low 20 cycles in total
    key_load_n = 1'b1;
    step(5);   // after release edge 4
    tests++; if (busy !== 1'b1)   begin fails++; $display("FAIL clean_release_busy: got %b expected 1", busy); end
    step(1);   // after release edge 5
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL clean_release_idle: got %b expected 0", busy); end
    tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL clean_pulses: got %0d expected 1", pulses - p0); end
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulses;
    key_load_n = 1'b0;
    step(2);
    key_load_n = 1'b1;
    step(1);   // after edge 2: debounce entered
    tests++; if (busy !== 1'b1)  begin fails++; $display("FAIL glitch_busy: got %b expected 1", busy); end
    step(2);   // after edge 4: rejected
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL glitch_idle: got %b expected 0", busy); end
    step(6);
    tests++; if (b_q !== 2'b10)  begin fails++; $display("FAIL glitch_b_q: got %b expected 10", b_q); end
    tests++; if (load_count !== 4'd1) begin fails++; $display("FAIL glitch_count: got %0d expected 1", load_count); end
    tests++; if (pulses - p0 !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d expected 0", pulses - p0); end
  endtask

  task automatic test_release_bounce();
    int p0;
    p0 = pulses;
    sw_b = 2'b01; key_load_n = 1'b0;
    step(10);
    tests++; if (load_count !== 4'd2) begin fails++; $display("FAIL bounce_count_load: got %0d expected 2", load_count); end
    key_load_n = 1'b1; step(1);
    key_load_n = 1'b0; step(1);
    key_load_n = 1'b1; step(1);
    key_load_n = 1'b0; step(1);
    key_load_n = 1'b1;
    step(5);
    tests++; if (busy !== 1'b1)  begin fails++; $display("FAIL bounce_busy: got %b expected 1", busy); end
    step(1);
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL bounce_idle: got %b expected 0", busy); end
    tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL bounce_pulses: got %0d expected 1", pulses - p0); end
    tests++; if (load_count !== 4'd2) begin fails++; $display("FAIL bounce_count: got %0d expected 2", load_count); end
    tests++; if (b_q !== 2'b01)  begin fails++; $display("FAIL bounce_b_q: got %b expected 01", b_q); end
  endtask

  task automatic test_switch_change();
    sw_b = 2'b01; key_load_n = 1'b0;
    step(2);
    sw_b = 2'b11;
    step(6);   // after edge 7
    tests++; if (b_q !== 2'b11)  begin fails++; $display("FAIL sw_change_b_q: got %b expected 11", b_q); end
    tests++; if (load_count !== 4'd3) begin fails++; $display("FAIL sw_change_count: got %0d expected 3", load_count); end
    key_load_n = 1'b1;
    step(6);
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL sw_change_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_debounce();
    sw_b = 2'b01; key_load_n = 1'b0;
    step(4);   // after edge 3, inside debounce
    tests++; if (busy !== 1'b1)  begin fails++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (b_q !== 2'b00)  begin fails++; $display("FAIL rst_mid_b_q: got %b expected 00", b_q); end
    tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", b_valid); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    tests++; if (load_count !== 4'd0) begin fails++; $display("FAIL rst_mid_count: got %0d expected 0", load_count); end
    tests++; if (b_load !== 1'b0) begin fails++; $display("FAIL rst_mid_load: got %b expected 0", b_load); end
    step(2);
    rst_n = 1'b1;  // key still held low
    step(6);   // after edge 5
    tests++; if (b_load !== 1'b0) begin fails++; $display("FAIL rst_held_early_load: got %b expected 0", b_load); end
    tests++; if (load_count !== 4'd0) begin fails++; $display("FAIL rst_held_early_count: got %0d expected 0", load_count); end
    step(1);   // after edge 6
    tests++; if (b_load !== 1'b1) begin fails++; $display("FAIL rst_held_load: got %b expected 1", b_load); end
    step(1);   // after edge 7
    tests++; if (b_q !== 2'b01)  begin fails++; $display("FAIL rst_held_b_q: got %b expected 01", b_q); end
    tests++; if (load_count !== 4'd1) begin fails++; $display("FAIL rst_held_count: got %0d expected 1", load_count); end
    key_load_n = 1'b1;
    step(6);
  endtask

  task automatic test_wrap();
    int p0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    p0 = pulses;
    for (int i = 1; i <= 16; i++) begin
      sw_b = 2'(i);
      key_load_n = 1'b0;
      step(8);
      key_load_n = 1'b1;
      step(6);
      if (i == 15) begin
        tests++; if (load_count !== 4'd15) begin fails++; $display("FAIL wrap_count15: got %0d expected 15", load_count); end
      end
    end
    tests++; if (load_count !== 4'd0) begin fails++; $display("FAIL wrap_count0: got %0d expected 0", load_count); end
    tests++; if (b_valid !== 1'b1) begin fails++; $display("FAIL wrap_valid: got %b expected 1", b_valid); end
    tests++; if (b_q !== 2'b00)  begin fails++; $display("FAIL wrap_b_q: got %b expected 00", b_q); end
    tests++; if (pulses - p0 !== 16) begin fails++; $display("FAIL wrap_pulses: got %0d expected 16", pulses - p0); end
  endtask

  initial begin
    tests = 0; fails = 0; pulses = 0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_switch_change();
    test_reset_mid_debounce();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
